// File: rtl/mc_pkg.sv
// Shared constants for the multicycle processor control path: instruction
// field encodings, ALU operation codes and the control FSM state encoding.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Shared with the ALU itself
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: turns the FSM's coarse aluOp request into the
// 3-bit ALU code, consulting funct only for R-type execution.
module alu_decoder
  import mc_pkg::*;
(
  input  aluop_t     aluOp,
  input  logic [5:0] funct,
  output logic [2:0] ALUControl
);

  // Unknown funct values fall back to add so an R-type always completes.
  always_comb begin
    ALUControl = ALU_ADD;
    case (aluOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_SLT:  ALUControl = ALU_SLT;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle datapath.
//   state    | meaning
//   RESET    | held while rst_n low, everything off
//   FETCH    | read instruction at PC, PC <= PC + 4
//   DECODE   | branch target into ALUOut, dispatch on opcode
//   MEMADR   | effective address A + imm
//   MEMREAD  | read data memory at ALUOut
//   MEMWB    | load data into rt
//   MEMWRITE | store B at ALUOut
//   EXECUTE  | R-type ALU op on A, B
//   ALUWB    | ALUOut into rd
//   BRANCH   | compare A - B, load target if zero
//   ADDIEX   | A + imm
//   ADDIWB   | ALUOut into rt
//   JUMP     | load jump target
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] ALUControl,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic [1:0] pcSrc,
  output logic       pcEn,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  aluop_t alu_op;
  logic   pc_write;
  logic   branch;

  // State register; reset parks the FSM in RESET with all enables low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // Next state and Moore outputs; illegal is the only opcode-dependent output.
  always_comb begin
    state_d  = state_q;
    alu_op   = ALUOP_ADD;
    aluSrcA  = 1'b0;
    aluSrcB  = 2'b00;
    adrSrc   = 1'b0;
    irWrite  = 1'b0;
    memWrite = 1'b0;
    regWrite = 1'b0;
    regDst   = 1'b0;
    memToReg = 1'b0;
    pcSrc    = 2'b00;
    pc_write = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        irWrite  = 1'b1;
        aluSrcB  = 2'b01;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        pcSrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcSrc    = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluOp      (alu_op),
    .funct      (funct),
    .ALUControl (ALUControl)
  );

  // zero is only meaningful while BRANCH has the ALU doing the compare.
  assign pcEn  = pc_write | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instructions with literal pins,
// then a random instruction stream (with occasional resets mid-instruction)
// checked every cycle against a per-instruction expected-output model.
module tb_multicycle_control;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       srcA;
    logic [1:0] srcB;
    logic       adrSrc;
    logic       irWrite;
    logic       memWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       illegal;
  } ctl_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

  logic       clk, rst_n, zero;
  logic [5:0] opcode, funct;
  logic [2:0] ALUControl;
  logic       aluSrcA, adrSrc, irWrite, memWrite, regWrite, regDst, memToReg, pcEn, illegal;
  logic [1:0] aluSrcB, pcSrc;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .ALUControl(ALUControl), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .adrSrc(adrSrc),
    .irWrite(irWrite), .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst),
    .memToReg(memToReg), .pcSrc(pcSrc), .pcEn(pcEn), .illegal(illegal), .state(state)
  );

  ctl_t act, exp_c;
  bit   exp_valid;
  int   checks, errors;

  assign act = {state, ALUControl, aluSrcA, aluSrcB, adrSrc, irWrite, memWrite,
                regWrite, regDst, memToReg, pcSrc, pcEn, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_c) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got %h exp %h", $time, act, exp_c);
      end
    end
  end

  task automatic pin(input string nm, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, a, e);
    end
  endtask

  task automatic check_ctl(input string nm, input ctl_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, e);
    end
  endtask

  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b000;
      6'b100010: return 3'b001;
      6'b100100: return 3'b010;
      6'b100101: return 3'b011;
      6'b101010: return 3'b101;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic int latency(input int kind);
    case (kind)
      K_LW:         return 5;
      K_SW, K_R:    return 4;
      K_ADDI:       return 4;
      K_BEQ, K_J:   return 3;
      default:      return 2;
    endcase
  endfunction

  function automatic bit reads_instr(input int kind, input int step);
    return (step == 1) || (step == 2 && (kind == K_LW || kind == K_SW || kind == K_R));
  endfunction

  // Expected outputs for cycle 'step' of an instruction, counted from its FETCH.
  function automatic ctl_t expect_cycle(input int kind, input int step,
                                        input logic [5:0] fn, input logic z);
    ctl_t e;
    e = '0;
    if (step == 0) begin
      e.st = S_FETCH; e.irWrite = 1'b1; e.srcB = 2'b01; e.pcEn = 1'b1;
    end else if (step == 1) begin
      e.st = S_DECODE; e.srcB = 2'b11; e.illegal = (kind == K_ILL);
    end else if ((kind == K_LW || kind == K_SW) && step == 2) begin
      e.st = S_MEMADR; e.srcA = 1'b1; e.srcB = 2'b10;
    end else if (kind == K_LW && step == 3) begin
      e.st = S_MEMREAD; e.adrSrc = 1'b1;
    end else if (kind == K_LW && step == 4) begin
      e.st = S_MEMWB; e.memToReg = 1'b1; e.regWrite = 1'b1;
    end else if (kind == K_SW && step == 3) begin
      e.st = S_MEMWRITE; e.adrSrc = 1'b1; e.memWrite = 1'b1;
    end else if (kind == K_R && step == 2) begin
      e.st = S_EXECUTE; e.srcA = 1'b1; e.alu = ref_alu(fn);
    end else if (kind == K_R && step == 3) begin
      e.st = S_ALUWB; e.regDst = 1'b1; e.regWrite = 1'b1;
    end else if (kind == K_ADDI && step == 2) begin
      e.st = S_ADDIEX; e.srcA = 1'b1; e.srcB = 2'b10;
    end else if (kind == K_ADDI && step == 3) begin
      e.st = S_ADDIWB; e.regWrite = 1'b1;
    end else if (kind == K_BEQ && step == 2) begin
      e.st = S_BRANCH; e.srcA = 1'b1; e.alu = 3'b001; e.pcSrc = 2'b01; e.pcEn = z;
    end else if (kind == K_J && step == 2) begin
      e.st = S_JUMP; e.pcSrc = 2'b10; e.pcEn = 1'b1;
    end
    return e;
  endfunction

  task automatic drive_noise();
    opcode = 6'($urandom_range(0, 63));
    funct  = 6'($urandom_range(0, 63));
    zero   = 1'($urandom_range(0, 1));
  endtask

  // Holds reset for n cycles, releases it, and returns just after the edge
  // that enters FETCH.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    exp_c = '0;
    exp_c.st = S_RESET;
    exp_valid = 1'b1;
    repeat (n) begin
      drive_noise();
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    drive_noise();
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                           input bit directed, input logic zdir, input int abort_step);
    ctl_t zero_ctl;
    int lat;
    lat = latency(kind);
    zero_ctl = '0;
    for (int s = 0; s < lat; s++) begin
      if (reads_instr(kind, s)) begin
        opcode = op;
        funct  = fn;
      end else begin
        opcode = 6'($urandom_range(0, 63));
        funct  = 6'($urandom_range(0, 63));
      end
      zero = directed ? zdir : 1'($urandom_range(0, 1));
      exp_c = expect_cycle(kind, s, fn, zero);
      exp_valid = 1'b1;
      if (s == abort_step) begin
        exp_valid = 1'b0;
        #1;
        check_ctl("pre_abort", exp_c);
        rst_n = 1'b0;
        #1;
        check_ctl("async_reset", zero_ctl);
        do_reset(2);
        return;
      end
      if (directed) begin
        #3;
        if (s == 0) begin
          pin("fetch_state", state, 4'd1);
          pin("fetch_irWrite", {3'b0, irWrite}, 4'd1);
          pin("fetch_pcEn", {3'b0, pcEn}, 4'd1);
        end
        if (kind == K_LW && s == 2) pin("lw_memadr_alu", {1'b0, ALUControl}, 4'd0);
        if (kind == K_LW && s == 4) begin
          pin("lw_memwb_regWrite", {3'b0, regWrite}, 4'd1);
          pin("lw_memwb_memToReg", {3'b0, memToReg}, 4'd1);
        end
        if (kind == K_R && s == 2 && fn == 6'b101010) begin
          pin("slt_alu", {1'b0, ALUControl}, 4'b0101);
          pin("slt_srcB", {2'b0, aluSrcB}, 4'd0);
        end
        if (kind == K_R && s == 3) pin("aluwb_regDst", {3'b0, regDst}, 4'd1);
        if (kind == K_BEQ && s == 2) begin
          pin("beq_alu", {1'b0, ALUControl}, 4'b0001);
          pin("beq_pcSrc", {2'b0, pcSrc}, 4'b0001);
          pin("beq_pcEn", {3'b0, pcEn}, {3'b0, zdir});
        end
        if (kind == K_ILL && s == 1) pin("illegal_pulse", {3'b0, illegal}, 4'd1);
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b001000 || op == 6'b000100 || op == 6'b000010;
  endfunction

  logic [5:0] legal_fn [5];
  logic [5:0] kind_op [6];

  initial begin
    int kind, ab;
    logic [5:0] op, fn;
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    kind_op  = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    checks = 0;
    errors = 0;
    exp_valid = 1'b0;
    rst_n = 1'b0;
    opcode = '0;
    funct = '0;
    zero = 1'b0;

    do_reset(3);

    run_instr(K_LW,  6'b100011, 6'b100000, 1'b1, 1'b0, -1);
    run_instr(K_R,   6'b000000, 6'b101010, 1'b1, 1'b0, -1);
    run_instr(K_BEQ, 6'b000100, 6'b000000, 1'b1, 1'b1, -1);
    run_instr(K_BEQ, 6'b000100, 6'b000000, 1'b1, 1'b0, -1);
    run_instr(K_ILL, 6'b111111, 6'b000000, 1'b1, 1'b0, -1);
    run_instr(K_SW,  6'b101011, 6'b000000, 1'b1, 1'b0, 3);
    run_instr(K_J,   6'b000010, 6'b000000, 1'b1, 1'b0, -1);
    run_instr(K_ADDI,6'b001000, 6'b000000, 1'b1, 1'b0, -1);

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 6);
      if (kind == K_ILL) begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = kind_op[kind];
      end
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
      else fn = legal_fn[$urandom_range(0, 4)];
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, latency(kind) - 1) : -1;
      run_instr(kind, op, fn, 1'b0, 1'b0, ab);
    end

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
